// File: rtl/fp_popcnt_stream.sv
// rtl/fp_popcnt_stream.sv - streaming pipelined popcount of multi-beat fingerprints; FP_POPCNT_AND_EN enables the A&B operand
module fp_popcnt_stream #(
    parameter int  BUS_WIDTH     = 512,
    parameter int  GRANULE_WIDTH = 6,
    parameter int  PIPE_DEPTH    = 3,
    parameter int  MAX_BEATS     = 4,
    localparam int CNT_W         = $clog2(BUS_WIDTH*MAX_BEATS+1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Valid,
    input  logic                 i_Last,
    input  logic                 i_Mode,
    input  logic [BUS_WIDTH-1:0] i_VecA,
    input  logic [BUS_WIDTH-1:0] i_VecB,
    output logic                 o_Valid,
    output logic [CNT_W-1:0]     o_Sum,
    output logic                 o_Overflow
);

    // Tree geometry: granule count padded up to a power of two so every level halves cleanly.
    localparam int NG        = (BUS_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
    localparam int PAD_W     = NG * GRANULE_WIDTH;
    localparam int LEAF_W    = $clog2(GRANULE_WIDTH + 1);
    localparam int LEVELS    = $clog2(NG);
    localparam int NP        = 1 << LEVELS;
    localparam int SUM_W     = LEAF_W + LEVELS;
    // At most one register per tree level; any surplus depth becomes a plain delay after the root.
    localparam int NREG_TREE = (PIPE_DEPTH < LEVELS) ? PIPE_DEPTH : LEVELS;
    localparam int TAIL      = PIPE_DEPTH - NREG_TREE;
    localparam int BI_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    // Bit offset of tree level l inside the flattened tree vectors.
    function automatic int lvl_off(input int l);
        int off;
        off = 0;
        for (int k = 0; k < l; k++) begin
            off = off + (NP >> k) * (LEAF_W + k);
        end
        return off;
    endfunction

    // True when a pipeline register sits after tree level l (spreads NREG_TREE evenly over LEVELS).
    function automatic bit reg_after(input int l);
        if (LEVELS == 0) begin
            return 1'b0;
        end
        return ((l * NREG_TREE) / LEVELS) > (((l - 1) * NREG_TREE) / LEVELS);
    endfunction

    // Popcount of a single LUT-sized granule.
    function automatic logic [LEAF_W-1:0] gran_pop(input logic [GRANULE_WIDTH-1:0] g);
        logic [LEAF_W-1:0] c;
        c = '0;
        for (int i = 0; i < GRANULE_WIDTH; i++) begin
            c = c + LEAF_W'(g[i]);
        end
        return c;
    endfunction

    localparam int TREE_BITS = lvl_off(LEVELS + 1);
    localparam int OFF_TOP   = lvl_off(LEVELS);

    logic [BUS_WIDTH-1:0] operand;
    logic [BUS_WIDTH-1:0] op_q;
    logic [PAD_W-1:0]     op_pad;
    logic [BI_W-1:0]      beat_idx;
    logic                 at_max;
    logic                 last_eff;
    logic                 force_c;
    logic [PIPE_DEPTH:0]  sv_valid;
    logic [PIPE_DEPTH:0]  sv_last;
    logic [PIPE_DEPTH:0]  sv_force;
    logic [SUM_W-1:0]     tree_cnt;
    logic [SUM_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     acc;
    logic [CNT_W-1:0]     total;

    // lvl_sum: combinational adder outputs; lvl_out: the same values after optional per-level registers.
    wire  [TREE_BITS-1:0] lvl_sum;
    wire  [TREE_BITS-1:0] lvl_out;

`ifdef FP_POPCNT_AND_EN
    assign operand = i_Mode ? (i_VecA & i_VecB) : i_VecA;
`else
    logic unused_and_inputs;
    assign operand           = i_VecA;
    assign unused_and_inputs = ^{i_Mode, i_VecB};
`endif

    // A beat at the last allowed index closes the fingerprint whether or not i_Last is set.
    assign at_max   = (beat_idx == BI_W'(MAX_BEATS - 1));
    assign last_eff = i_Last | at_max;
    assign force_c  = i_Valid & at_max & ~i_Last;

    // Input-side beat index within the current fingerprint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx <= '0;
        end else if (i_Valid) begin
            beat_idx <= last_eff ? '0 : beat_idx + 1'b1;
        end
    end

    // Shadow pipeline: beat qualifiers travel alongside the input register and tree registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv_valid <= '0;
            sv_last  <= '0;
            sv_force <= '0;
        end else begin
            sv_valid <= {sv_valid[PIPE_DEPTH-1:0], i_Valid};
            sv_last  <= {sv_last[PIPE_DEPTH-1:0], i_Valid & last_eff};
            sv_force <= {sv_force[PIPE_DEPTH-1:0], force_c};
        end
    end

    // Input operand register; datapath carries no reset because the valid pipeline qualifies it.
    always_ff @(posedge clk) begin
        op_q <= operand;
    end

    assign op_pad = PAD_W'(op_q);

    for (genvar g = 0; g < NP; g++) begin : g_leaf
        if (g < NG) begin : g_real
            assign lvl_sum[g*LEAF_W +: LEAF_W] = gran_pop(op_pad[g*GRANULE_WIDTH +: GRANULE_WIDTH]);
        end else begin : g_pad
            assign lvl_sum[g*LEAF_W +: LEAF_W] = '0;
        end
    end

    assign lvl_out[0 +: NP*LEAF_W] = lvl_sum[0 +: NP*LEAF_W];

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int NL      = NP >> l;
        localparam int WL      = LEAF_W + l;
        localparam int OFF_IN  = lvl_off(l - 1);
        localparam int OFF_OUT = lvl_off(l);

        for (genvar j = 0; j < NL; j++) begin : g_add
            assign lvl_sum[OFF_OUT + j*WL +: WL] =
                {1'b0, lvl_out[OFF_IN + (2*j)*(WL-1) +: WL-1]} +
                {1'b0, lvl_out[OFF_IN + (2*j+1)*(WL-1) +: WL-1]};
        end

        if (reg_after(l)) begin : g_reg
            logic [NL*WL-1:0] q;
            // Pipeline register closing this group of tree levels.
            always_ff @(posedge clk) begin
                q <= lvl_sum[OFF_OUT +: NL*WL];
            end
            assign lvl_out[OFF_OUT +: NL*WL] = q;
        end else begin : g_wire
            assign lvl_out[OFF_OUT +: NL*WL] = lvl_sum[OFF_OUT +: NL*WL];
        end
    end

    assign tree_cnt = lvl_out[OFF_TOP +: SUM_W];

    if (TAIL == 0) begin : g_no_tail
        assign beat_cnt = tree_cnt;
    end else begin : g_tail
        logic [SUM_W-1:0] dly [TAIL];
        // Extra delay when there are more pipeline stages than tree levels.
        always_ff @(posedge clk) begin
            dly[0] <= tree_cnt;
            for (int k = 1; k < TAIL; k++) begin
                dly[k] <= dly[k-1];
            end
        end
        assign beat_cnt = dly[TAIL-1];
    end

    // acc is zero whenever no fingerprint is open, so the first beat simply loads its count.
    assign total = acc + CNT_W'(beat_cnt);

    // Fingerprint accumulator and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            o_Valid    <= 1'b0;
            o_Sum      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            o_Valid <= 1'b0;
            if (sv_valid[PIPE_DEPTH]) begin
                if (sv_last[PIPE_DEPTH]) begin
                    o_Valid    <= 1'b1;
                    o_Sum      <= total;
                    o_Overflow <= sv_force[PIPE_DEPTH];
                    acc        <= '0;
                end else begin
                    acc <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_popcnt_stream.sv
// tb/tb_fp_popcnt_stream.sv - self-checking bench for fp_popcnt_stream
module tb_fp_popcnt_stream;

    localparam int BW     = 48;
    localparam int PD     = 2;
    localparam int MB     = 4;
    localparam int CW     = $clog2(BW*MB+1);
    localparam int PERIOD = 10;
`ifdef FP_POPCNT_AND_EN
    localparam bit AND_EN = 1'b1;
`else
    localparam bit AND_EN = 1'b0;
`endif

    typedef struct {
        longint due;
        int     sum;
        bit     ovf;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          i_Valid;
    logic          i_Last;
    logic          i_Mode;
    logic [BW-1:0] i_VecA;
    logic [BW-1:0] i_VecB;
    logic          o_Valid;
    logic [CW-1:0] o_Sum;
    logic          o_Overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   m_sum    = 0;
    int   m_idx    = 0;
    int   held_sum = 0;
    bit   held_ovf = 1'b0;

    fp_popcnt_stream #(
        .BUS_WIDTH    (BW),
        .GRANULE_WIDTH(6),
        .PIPE_DEPTH   (PD),
        .MAX_BEATS    (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_Valid   (i_Valid),
        .i_Last    (i_Last),
        .i_Mode    (i_Mode),
        .i_VecA    (i_VecA),
        .i_VecB    (i_VecB),
        .o_Valid   (o_Valid),
        .o_Sum     (o_Sum),
        .o_Overflow(o_Overflow)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return {BW{1'b1}};
            1:       return '0;
            default: return t[BW-1:0];
        endcase
    endfunction

    // Drive one cycle; the reference model tracks fingerprints and schedules expected results.
    task automatic beat(input bit v, input bit l, input bit m,
                        input logic [BW-1:0] a, input logic [BW-1:0] b);
        longint        t_acc;
        logic [BW-1:0] op;
        exp_t          e;
        i_Valid = v;
        i_Last  = l;
        i_Mode  = m;
        i_VecA  = a;
        i_VecB  = b;
        @(posedge clk);
        t_acc = longint'($time);
        #1;
        if (v) begin
            op    = (AND_EN && m) ? (a & b) : a;
            m_sum = m_sum + $countones(op);
            m_idx = m_idx + 1;
            if (l || m_idx == MB) begin
                e.due = t_acc + (PD + 1) * PERIOD;
                e.sum = m_sum;
                e.ovf = !l;
                q.push_back(e);
                m_sum = 0;
                m_idx = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            beat(1'b0, ($urandom_range(0, 1) == 1), 1'b0, rnd48(), rnd48());
        end
    endtask

    task automatic do_reset();
        i_Valid = 1'b0;
        rst     = 1'b1;
        q.delete();
        m_sum = 0;
        m_idx = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Every cycle: outputs must match the scheduled result, or stay quiet and hold.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_valid", longint'(o_Valid), 0);
            chk("reset_sum", longint'(o_Sum), 0);
            chk("reset_ovf", longint'(o_Overflow), 0);
            held_sum = 0;
            held_ovf = 1'b0;
        end else if (q.size() != 0 && q[0].due == longint'($time) - PERIOD/2) begin
            chk("valid_pulse", longint'(o_Valid), 1);
            chk("sum", longint'(o_Sum), longint'(q[0].sum));
            chk("overflow", longint'(o_Overflow), longint'(q[0].ovf));
            held_sum = q[0].sum;
            held_ovf = q[0].ovf;
            void'(q.pop_front());
        end else begin
            chk("valid_idle", longint'(o_Valid), 0);
            chk("sum_hold", longint'(o_Sum), longint'(held_sum));
            chk("ovf_hold", longint'(o_Overflow), longint'(held_ovf));
        end
    end

    initial begin
        int wait_cyc;
        rst     = 1'b1;
        i_Valid = 1'b0;
        i_Last  = 1'b0;
        i_Mode  = 1'b0;
        i_VecA  = '0;
        i_VecB  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // single all-ones beat
        beat(1'b1, 1'b1, 1'b0, 48'hFFFFFFFFFFFF, rnd48());
        idle(5);

        // two beats with an idle gap
        beat(1'b1, 1'b0, 1'b0, 48'hF0F0F0F0F0F0, rnd48());
        idle(1);
        beat(1'b1, 1'b1, 1'b0, 48'h666666666666, rnd48());
        idle(5);

        // back-to-back single-beat fingerprints
        beat(1'b1, 1'b1, 1'b0, 48'h111111111111, rnd48());
        beat(1'b1, 1'b1, 1'b0, 48'hFFFFFFFFFFFF, rnd48());
        beat(1'b1, 1'b1, 1'b0, 48'h000000000000, rnd48());
        idle(5);

        // AND mode
        beat(1'b1, 1'b0, 1'b1, 48'hFFFFFFFFFFFF, 48'h0F0F0F0F0F0F);
        beat(1'b1, 1'b1, 1'b1, 48'hFFFFFFFFFFFF, 48'h0F0F0F0F0F0F);
        idle(5);

        // force-close after MAX_BEATS, fifth beat starts a new fingerprint
        for (int k = 0; k < MB; k++) begin
            beat(1'b1, 1'b0, 1'b0, 48'hFFFFFFFFFFFF, rnd48());
        end
        beat(1'b1, 1'b1, 1'b0, 48'hFFFFFFFFFFFF, rnd48());
        idle(5);

        // reset mid-fingerprint discards it
        beat(1'b1, 1'b0, 1'b0, 48'hFFFFFFFFFFFF, rnd48());
        do_reset();
        beat(1'b1, 1'b1, 1'b0, 48'h000000000003, rnd48());
        idle(5);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                beat(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 1) == 1), rnd48(), rnd48());
            end
        end

        // drain outstanding results
        i_Valid  = 1'b0;
        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 40) begin
            @(posedge clk);
            wait_cyc++;
        end
        #1;
        chk("drain_pending", longint'(q.size()), 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
